fdc_universal_reg: RTL
======================

// Module: fdc_universal_reg
// PURPOSE
//   Parametrised WIDTH-bit register built on clear-able D flip-flops, with clock enable and mode select.
//   Mode select chooses hold, parallel load, shift left/right, increment, decrement or synchronous clear.
//   Serves as the CPU's general register, shifter and counter (A/B regs, PC, step counter).
//   Adds asynchronous active-low clear, enable, modes and a registered carry/borrow flag.
// PARAMETERS
//   WIDTH        8     data width in bits; legal range 2..32
//   RESET_VALUE  0     value of output_q after async clear and after mode SCLR (WIDTH bits)
// PORTS
//   clock           in   1      single clock; all state changes on rising edge
//   input_clear_n   in   1      asynchronous, active-low clear of all state
//   input_enable    in   1      1 = apply input_mode this edge; 0 = hold all state incl. output_carry
//   input_mode      in   3      operation select (see BEHAVIOUR)
//   input_d         in   WIDTH  parallel load data
//   input_serial_l  in   1      bit shifted into MSB on SHR
//   input_serial_r  in   1      bit shifted into LSB on SHL
//   output_q        out  WIDTH  register contents
//   output_carry    out  1      registered shift-out / carry / borrow flag
//   output_zero     out  1      combinational: 1 when output_q == 0
// BEHAVIOUR
//   - One clock, reset asynchronous and active-low: input_clear_n=0 forces output_q=RESET_VALUE and
//     output_carry=0 immediately, independent of clock; held while low. Enable/mode ignored during clear.
//   - Release: first rising edge with input_clear_n=1 performs a normal operation. No settling cycles.
//   - Clear asserted mid-operation aborts it; no partial update survives.
//   - Latency: one edge. output_q/output_carry reflect the operation after the edge where enable=1.
//   - Modes (applied only when input_enable=1; q = output_q before the edge):
//     0 HOLD : q, carry unchanged
//     1 LOAD : q <= input_d; carry <= 0
//     2 SHL  : q <= {q[WIDTH-2:0], input_serial_r}; carry <= q[WIDTH-1]
//     3 SHR  : q <= {input_serial_l, q[WIDTH-1:1]}; carry <= q[0]
//     4 INC  : q <= q + 1 mod 2^WIDTH; carry <= (q == all-ones). Wrap all-ones -> 0 sets carry=1
//     5 DEC  : q <= q - 1 mod 2^WIDTH; carry <= (q == 0) (borrow). Wrap 0 -> all-ones sets carry=1
//     6 SCLR : q <= RESET_VALUE; carry <= 0
//     7 rsvd : treated as HOLD
//   - Carry is a flag of the last operation: it persists through HOLD and enable=0.
//     Not sticky: the next INC/DEC/shift rewrites it.
//   - Arithmetic is unsigned, exactly WIDTH bits; the carry is the only overflow indicator.
//   - output_zero is derived combinationally from output_q; not registered, no extra latency.
//   - No X propagation from unused inputs: input_d ignored except in LOAD; serial inputs ignored
//     except in their own shift mode.
// STRUCTURE
//   - Shared package fdc_pkg: mode constants/enum for modes 0..7 (3-bit encoding above).
//     It is used by the sequencer that drives input_mode.
//   - Sub-module fdce_cell: 1-bit D flip-flop with async active-low clear, clear value and enable.
//     Instantiated WIDTH times for q, plus once for carry.
//     Per-bit clear value is taken from RESET_VALUE[i].
//   - Next-state mux and +1/-1 logic are combinational in the top level. Only the cells hold state.
// TESTING  (WIDTH=8, RESET_VALUE=0 unless stated)
//   - Async clear: load 8'hA5, drop input_clear_n between edges.
//     -> q=8'h00, carry=0 immediately (before next edge).
//   - Enable/hold: LOAD 8'h3C with enable=0 -> q unchanged.
//     Enable=1 -> q=8'h3C after one edge; mode 7 keeps 8'h3C.
//   - Shifts: q=8'h81, SHL with serial_r=0 -> q=8'h02, carry=1.
//     Then SHR with serial_l=1 -> q=8'h81, carry=0.
//   - Increment wrap: load 8'hFE, INC x2.
//     -> 8'hFF carry=0, then 8'h00 carry=1 and zero=1; HOLD keeps carry=1.
//   - Decrement borrow: q=8'h01, DEC x2 -> 8'h00 (zero=1, carry=0), then 8'hFF carry=1.
//   - RESET_VALUE=8'h10: async clear and SCLR both give q=8'h10, carry=0.
//     Clear asserted during an INC sequence holds q=8'h10 until release.

Source files
------------

// File: rtl/fdc_pkg.sv
// Shared mode encoding for the universal register and the sequencer that drives it.
package fdc_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_INC  = 3'd4,
    MODE_DEC  = 3'd5,
    MODE_SCLR = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

endpackage

// File: rtl/fdce_cell.sv
// 1-bit D flip-flop with asynchronous active-low clear to a per-cell value and clock enable.
module fdce_cell #(
  parameter logic CLEAR_VALUE = 1'b0
) (
  input  logic clock,
  input  logic clear_n,
  input  logic enable,
  input  logic d,
  output logic q
);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      q <= CLEAR_VALUE;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fdc_universal_reg.sv
// WIDTH-bit hold/load/shift/count register with async clear and a registered carry/borrow flag.
module fdc_universal_reg
  import fdc_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             input_clear_n,
  input  logic             input_enable,
  input  logic [2:0]       input_mode,
  input  logic [WIDTH-1:0] input_d,
  input  logic             input_serial_l,
  input  logic             input_serial_r,
  output logic [WIDTH-1:0] output_q,
  output logic             output_carry,
  output logic             output_zero
);

  logic [WIDTH-1:0] next_q;
  logic             next_carry;
  mode_e            mode;

  assign mode = mode_e'(input_mode);

  // Next-state selection; HOLD and the reserved code recirculate current state.
  always_comb begin
    next_q     = output_q;
    next_carry = output_carry;
    case (mode)
      MODE_LOAD: begin
        next_q     = input_d;
        next_carry = 1'b0;
      end
      MODE_SHL: begin
        next_q     = {output_q[WIDTH-2:0], input_serial_r};
        next_carry = output_q[WIDTH-1];
      end
      MODE_SHR: begin
        next_q     = {input_serial_l, output_q[WIDTH-1:1]};
        next_carry = output_q[0];
      end
      MODE_INC: begin
        next_q     = output_q + WIDTH'(1);
        next_carry = &output_q;
      end
      MODE_DEC: begin
        next_q     = output_q - WIDTH'(1);
        next_carry = ~|output_q;
      end
      MODE_SCLR: begin
        next_q     = RESET_VALUE;
        next_carry = 1'b0;
      end
      default: begin
        next_q     = output_q;
        next_carry = output_carry;
      end
    endcase
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    fdce_cell #(
      .CLEAR_VALUE (RESET_VALUE[i])
    ) u_cell (
      .clock   (clock),
      .clear_n (input_clear_n),
      .enable  (input_enable),
      .d       (next_q[i]),
      .q       (output_q[i])
    );
  end

  fdce_cell #(
    .CLEAR_VALUE (1'b0)
  ) u_carry (
    .clock   (clock),
    .clear_n (input_clear_n),
    .enable  (input_enable),
    .d       (next_carry),
    .q       (output_carry)
  );

  assign output_zero = (output_q == '0);

endmodule
